// File: rtl/quat_norm_sq_unit_pkg.sv
// Shared definitions for the quaternion sum-of-squares unit: widths, FSM
// state type and Q2.30 constants. Package name: quat_norm_pkg.
package quat_norm_pkg;

   localparam int DATA_W = 32;  // component and result width
   localparam int FRAC_W = 30;  // Q2.30 fractional bits
   localparam int ACC_W  = 36;  // holds four squares of -2.0 (2^34) with margin

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [DATA_W-1:0] ONE_Q230 = 32'h4000_0000;
   localparam logic [DATA_W-1:0] SAT_Q230 = 32'hFFFF_FFFF;

   // Clamp the accumulator into an unsigned Q2.30 result; anything >= 4.0 saturates.
   function automatic logic [DATA_W-1:0] clamp_norm(input logic [ACC_W-1:0] acc);
      if (acc[ACC_W-1:DATA_W] != '0) return SAT_Q230;
      return acc[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/quat_norm_sq_unit_if.sv
// Quaternion-in / norm-out stream bundle for quat_norm_sq_unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer keeps valid and data stable until that edge, and
// the consumer may raise or drop ready at any time.
interface quat_norm_sq_unit_if;
   import quat_norm_pkg::*;

   // input side
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] qw_in;
   logic [DATA_W-1:0] qx_in;
   logic [DATA_W-1:0] qy_in;
   logic [DATA_W-1:0] qz_in;

   // output side
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] norm_sq;
   logic              norm_zero;
   logic              norm_sat;
   logic [DATA_W-1:0] qw_out;
   logic [DATA_W-1:0] qx_out;
   logic [DATA_W-1:0] qy_out;
   logic [DATA_W-1:0] qz_out;

   // The norm unit itself.
   modport slave (
      input  in_valid, qw_in, qx_in, qy_in, qz_in, out_ready,
      output in_ready, out_valid, norm_sq, norm_zero, norm_sat,
             qw_out, qx_out, qy_out, qz_out
   );

   // Upstream producer plus downstream consumer.
   modport master (
      output in_valid, qw_in, qx_in, qy_in, qz_in, out_ready,
      input  in_ready, out_valid, norm_sq, norm_zero, norm_sat,
             qw_out, qx_out, qy_out, qz_out
   );

endinterface

// File: rtl/quat_norm_sq_unit_sq_mul.sv
// quat_sq_mul: signed Q2.30 squarer. The 64-bit Q4.60 square is shifted down
// by FRAC_W with plain truncation and zero-extended to ACC_W.
// QNORM_PIPE_MUL_EN adds an output register (one cycle of latency).
module quat_sq_mul
   import quat_norm_pkg::*;
(
`ifdef QNORM_PIPE_MUL_EN
   input  logic                     clk,
   input  logic                     rst,
`endif
   input  logic signed [DATA_W-1:0] a_i,
   output logic        [ACC_W-1:0]  sq_o
);

   logic signed [2*DATA_W-1:0] prod;
   logic        [ACC_W-1:0]    sq_comb;

   // A square is never negative, so a logical shift is exact truncation.
   assign prod    = a_i * a_i;
   assign sq_comb = ACC_W'(unsigned'(prod) >> FRAC_W);

`ifdef QNORM_PIPE_MUL_EN
   logic [ACC_W-1:0] sq_q;

   // Register the square to break the multiply-to-accumulate path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sq_q <= '0;
      else     sq_q <= sq_comb;
   end

   assign sq_o = sq_q;
`else
   assign sq_o = sq_comb;
`endif

endmodule

// File: rtl/quat_norm_sq_unit.sv
// quat_norm_sq_unit: serial |q|^2 for the quaternion normalizer. Squares
// w, x, y, z one per cycle through a shared squarer and accumulates, then
// holds an unsigned Q2.30 result with zero/saturation flags.
// Optional: QNORM_PIPE_MUL_EN registers the squarer (ACCUM grows to 5 cycles).
module quat_norm_sq_unit
   import quat_norm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   quat_norm_sq_unit_if.slave bus,
   output state_e             dbg_state_o
);

`ifdef QNORM_PIPE_MUL_EN
   // Index 0 only primes the squarer register; indices 1..4 accumulate.
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] qw_q, qw_d, qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
   logic [DATA_W-1:0] norm_q, norm_d;
   logic              zero_q, zero_d;
   logic              sat_q, sat_d;

   logic              accept;
   logic              last;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] comp_sel;
   logic [ACC_W-1:0]  sq;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (idx_q == LAST_IDX) begin
               last    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Component select for the shared squarer; index 4 (pipelined build) is a don't-care.
   always_comb begin
      comp_sel = qw_q;
      case (idx_q[1:0])
         2'd0:    comp_sel = qw_q;
         2'd1:    comp_sel = qx_q;
         2'd2:    comp_sel = qy_q;
         default: comp_sel = qz_q;
      endcase
   end

   quat_sq_mul u_sq_mul (
`ifdef QNORM_PIPE_MUL_EN
      .clk  (clk),
      .rst  (rst),
`endif
      .a_i  (comp_sel),
      .sq_o (sq)
   );

   // Datapath: latch on accept, accumulate during ACCUM, capture the result on the last step.
   always_comb begin
      idx_d  = idx_q;
      acc_d  = acc_q;
      qw_d   = qw_q;
      qx_d   = qx_q;
      qy_d   = qy_q;
      qz_d   = qz_q;
      norm_d = norm_q;
      zero_d = zero_q;
      sat_d  = sat_q;
      if (accept) begin
         qw_d  = bus.qw_in;
         qx_d  = bus.qx_in;
         qy_d  = bus.qy_in;
         qz_d  = bus.qz_in;
         acc_d = '0;
         idx_d = '0;
      end else if (state_q == ACCUM) begin
         idx_d = idx_q + 3'd1;
`ifdef QNORM_PIPE_MUL_EN
         if (idx_q != 3'd0) acc_d = acc_q + sq;
`else
         acc_d = acc_q + sq;
`endif
         if (last) begin
            idx_d  = '0;
            norm_d = clamp_norm(acc_d);
            zero_d = (acc_d == '0);
            sat_d  = (acc_d[ACC_W-1:DATA_W] != '0);
         end
      end
   end

   // Datapath registers; reset clears everything so an aborted transaction leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         acc_q  <= '0;
         qw_q   <= '0;
         qx_q   <= '0;
         qy_q   <= '0;
         qz_q   <= '0;
         norm_q <= '0;
         zero_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         acc_q  <= acc_d;
         qw_q   <= qw_d;
         qx_q   <= qx_d;
         qy_q   <= qy_d;
         qz_q   <= qz_d;
         norm_q <= norm_d;
         zero_q <= zero_d;
         sat_q  <= sat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.norm_sq   = norm_q;
   assign bus.norm_zero = zero_q;
   assign bus.norm_sat  = sat_q;
   assign bus.qw_out    = qw_q;
   assign bus.qx_out    = qx_q;
   assign bus.qy_out    = qy_q;
   assign bus.qz_out    = qz_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_quat_norm_sq_unit.sv
// Directed bench for quat_norm_sq_unit: hand-computed norms, latency,
// backpressure and mid-transaction reset. Honours QNORM_PIPE_MUL_EN.
module tb_quat_norm_sq_unit;
   import quat_norm_pkg::*;

`ifdef QNORM_PIPE_MUL_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 5;
`endif

   logic   clk;
   logic   rst;
   state_e dbg_state;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [DATA_W-1:0] exp_q[$];

   quat_norm_sq_unit_if bus();

   quat_norm_sq_unit dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] w, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z);
      bus.in_valid = 1'b1;
      bus.qw_in    = w;
      bus.qx_in    = x;
      bus.qy_in    = y;
      bus.qz_in    = z;
   endtask

   // Starts and ends on a falling edge. hold > 0 keeps out_ready low for that
   // many cycles after out_valid, offering a fresh w=1.0 quaternion meanwhile.
   task automatic run_txn(input logic [31:0] w, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z,
                          input logic [31:0] exp_n, input logic exp_z,
                          input logic exp_s, input int hold);
      logic [DATA_W-1:0] e;
      exp_q.push_back(exp_n);
      bus.out_ready = (hold == 0);
      drive(w, x, y, z);
      check("accept_ready", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.qw_in    = 32'h1234_5678;  // scramble inputs: outputs must come from the latch
      for (int c = 1; c < LAT; c++) begin
         check("busy_out_valid", bus.out_valid, 0);
         check("busy_in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      e = exp_q.pop_front();
      check("lat_out_valid", bus.out_valid, 1);
      check("norm_sq", bus.norm_sq, e);
      check("norm_zero", bus.norm_zero, exp_z);
      check("norm_sat", bus.norm_sat, exp_s);
      check("qw_out", bus.qw_out, w);
      check("qx_out", bus.qx_out, x);
      check("qy_out", bus.qy_out, y);
      check("qz_out", bus.qz_out, z);
      for (int h = 0; h < hold; h++) begin
         drive(ONE_Q230, 32'h0, 32'h0, 32'h0);
         @(negedge clk);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_norm_sq", bus.norm_sq, e);
         check("bp_norm_sat", bus.norm_sat, exp_s);
         check("bp_qw_out", bus.qw_out, w);
         check("bp_qz_out", bus.qz_out, z);
         check("bp_state", dbg_state, HOLD);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_out_valid", bus.out_valid, 0);
      check("post_in_ready", bus.in_ready, 1);
      check("post_state", dbg_state, IDLE);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.qw_in     = '0;
      bus.qx_in     = '0;
      bus.qy_in     = '0;
      bus.qz_in     = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_norm_sq", bus.norm_sq, 0);
      check("rst_norm_zero", bus.norm_zero, 0);
      check("rst_norm_sat", bus.norm_sat, 0);
      check("rst_qw_out", bus.qw_out, 0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b0;
      @(negedge clk);

      // 1: unit quaternion, 1.0^2 = 1.0
      run_txn(32'h4000_0000, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 0);
      // 2: mixed signs, 4 * 0.25 = 1.0
      run_txn(32'h2000_0000, 32'hE000_0000, 32'hE000_0000, 32'h2000_0000,
              32'h4000_0000, 1'b0, 1'b0, 0);
      // 3: four (-2.0)^2 = 16.0 -> clamp
      run_txn(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
              32'hFFFF_FFFF, 1'b0, 1'b1, 0);
      // 4: zero quaternion
      run_txn(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
      // single -2.0: exactly 4.0 still saturates
      run_txn(32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
      // truncation: 2^-30 squared is below one LSB -> 0; 0.5^2 + 0.75^2 = 0.8125
      run_txn(32'h0000_0001, 32'h2000_0000, 32'h3000_0000, 32'h0,
              32'h3400_0000, 1'b0, 1'b0, 0);

      // 5: backpressure 4 cycles, then the pending w=1.0 is taken only after the handshake
      run_txn(32'h2000_0000, 32'h2000_0000, 32'h0, 32'hE000_0000,
              32'h3000_0000, 1'b0, 1'b0, 4);
      check("bp_pending_valid", bus.in_valid, 1);
      run_txn(ONE_Q230, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 0);

      // 6: reset during cycle 2 of ACCUM aborts the transaction
      drive(32'h8000_0000, 32'h8000_0000, 32'h2000_0000, 32'h2000_0000);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_state", dbg_state, ACCUM);
      rst = 1'b1;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_in_ready", bus.in_ready, 1);
      check("arst_norm_sq", bus.norm_sq, 0);
      check("arst_qw_out", bus.qw_out, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         check("abort_out_valid", bus.out_valid, 0);
         check("abort_in_ready", bus.in_ready, 1);
      end
      run_txn(ONE_Q230, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
